hc02_bist_ctrl: RTL and testbench

//  Built-in self-test sequencer for the 74HC02 quad 2-input NOR resource (A/B -> Y = ~(A|B)).
//  It drives 8 test steps onto all NOR gates and samples Y after a settle window.
//  It checks each Y against the expected NOR, then reports per-gate fail flags and an error count.
//  It sits between the board-level HC02 pins (or the HC02 netlist) and a host control/status port.

---
 rtl/hc02_bist_ctrl_pkg.sv | 15 +
 rtl/hc02_bist_ctrl_vec_gen.sv | 30 +++
 rtl/hc02_bist_ctrl.sv | 150 +++++++++++++++
 tb/tb_hc02_bist_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/hc02_bist_ctrl_pkg.sv
// Shared definitions for the HC02 NOR-gate BIST sequencer: state encoding and step count.
package hc02_bist_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int N_STEPS           = 8;
  localparam int SETTLE_CYCLES_DEF = 4;

endpackage

// File: rtl/hc02_bist_ctrl_vec_gen.sv
// Combinational step-to-pattern map: drives every gate through all four input pairs,
// first in lock-step, then rotated per gate so neighbours see differing inputs.
module hc02_bist_ctrl_vec_gen
  import hc02_bist_ctrl_pkg::*;
#(
  parameter int GATES = 4
) (
  input  logic [2:0]     step_i,
  output logic [GATES:1] a_o,
  output logic [GATES:1] b_o
);

  logic [1:0] k;
  logic [1:0] gLow;

  // k = s for s<4, else (s+g) mod 4; only the low two bits of s and g matter mod 4.
  always_comb begin
    a_o  = '0;
    b_o  = '0;
    k    = '0;
    gLow = '0;
    for (int g = 1; g <= GATES; g++) begin
      gLow = 2'(g);
      k    = step_i[2] ? (step_i[1:0] + gLow) : step_i[1:0];
      a_o[g] = k[1];
      b_o[g] = k[0];
    end
  end

endmodule

// File: rtl/hc02_bist_ctrl.sv
// BIST sequencer for a 74HC02 quad NOR: drives 8 patterns, compares synchronised Y
// against ~(A|B), and reports sticky per-gate fail flags plus a saturating error count.
module hc02_bist_ctrl
  import hc02_bist_ctrl_pkg::*;
#(
  parameter int GATES         = 4,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int ERR_W         = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [GATES:1]   y_i,
  output logic [GATES:1]   a_o,
  output logic [GATES:1]   b_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] errCnt_o,
  output logic [GATES:1]   failMask_o
);

  localparam int          CNT_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [31:0] ERR_MAX = 32'((64'd1 << ERR_W) - 64'd1);

  state_t             state_q;
  logic [2:0]         step_q;
  logic [CNT_W-1:0]   settleCnt_q;
  logic [GATES:1]     a_q, b_q;
  logic [GATES:1]     syncMeta_q, syncY_q;
  logic               busy_q, done_q, pass_q;
  logic [ERR_W-1:0]   errCnt_q, errCnt_d;
  logic [GATES:1]     failMask_q, failMask_d;

  logic [GATES:1]     vecA, vecB;
  logic [GATES:1]     mismatch;
  logic [31:0]        popCnt;
  logic [31:0]        errSum;

  hc02_bist_ctrl_vec_gen #(.GATES(GATES)) u_vec_gen (
    .step_i (step_q),
    .a_o    (vecA),
    .b_o    (vecB)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      syncMeta_q <= '0;
      syncY_q    <= '0;
    end else begin
      syncMeta_q <= y_i;
      syncY_q    <= syncMeta_q;
    end
  end

  always_comb begin
    mismatch = syncY_q ^ ~(a_q | b_q);
    popCnt   = '0;
    for (int g = 1; g <= GATES; g++) begin
      popCnt = popCnt + 32'(mismatch[g]);
    end
    errSum     = 32'(errCnt_q) + popCnt;
    errCnt_d   = (errSum > ERR_MAX) ? ERR_W'(ERR_MAX) : ERR_W'(errSum);
    failMask_d = failMask_q | mismatch;
  end

  // ABORT overrides every state; in IDLE it also masks a simultaneous START.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      settleCnt_q <= '0;
      a_q         <= '0;
      b_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      errCnt_q    <= '0;
      failMask_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        state_q     <= ST_IDLE;
        busy_q      <= 1'b0;
        a_q         <= '0;
        b_q         <= '0;
        settleCnt_q <= '0;
        if (state_q != ST_IDLE) pass_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              state_q    <= ST_DRIVE;
              busy_q     <= 1'b1;
              step_q     <= '0;
              errCnt_q   <= '0;
              failMask_q <= '0;
              pass_q     <= 1'b0;
            end
          end
          ST_DRIVE: begin
            a_q         <= vecA;
            b_q         <= vecB;
            settleCnt_q <= '0;
            state_q     <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (settleCnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
              state_q <= ST_CHECK;
            end else begin
              settleCnt_q <= settleCnt_q + 1'b1;
            end
          end
          ST_CHECK: begin
            errCnt_q   <= errCnt_d;
            failMask_q <= failMask_d;
            if (step_q != 3'(N_STEPS - 1)) begin
              step_q  <= step_q + 3'd1;
              state_q <= ST_DRIVE;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              pass_q  <= (errCnt_d == '0);
              a_q     <= '0;
              b_q     <= '0;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign a_o        = a_q;
  assign b_o        = b_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_o     = pass_q;
  assign errCnt_o   = errCnt_q;
  assign failMask_o = failMask_q;

endmodule

// File: tb/tb_hc02_bist_ctrl.sv
// Directed bench for hc02_bist_ctrl: ideal, stuck-gate, saturation, abort, reset and re-start runs.
module tb_hc02_bist_ctrl;

  logic       clk;
  logic       rstN;
  logic       start;
  logic       abort;
  logic [1:0] yMode;
  logic [4:1] yIn;
  logic [4:1] aOut, bOut, failMask;
  logic       busy, done, pass;
  logic [7:0] errCnt;

  logic [4:1] aOut2, bOut2, failMask2;
  logic       busy2, done2, pass2;
  logic [3:0] errCnt2;

  int checks = 0;
  int errors = 0;
  int sawDone;

  hc02_bist_ctrl #(.GATES(4), .SETTLE_CYCLES(4), .ERR_W(8)) dut (
    .clk_i(clk), .rst_n_i(rstN), .start_i(start), .abort_i(abort), .y_i(yIn),
    .a_o(aOut), .b_o(bOut), .busy_o(busy), .done_o(done), .pass_o(pass),
    .errCnt_o(errCnt), .failMask_o(failMask)
  );

  hc02_bist_ctrl #(.GATES(4), .SETTLE_CYCLES(4), .ERR_W(4)) dutSat (
    .clk_i(clk), .rst_n_i(rstN), .start_i(start), .abort_i(abort), .y_i(4'b1111),
    .a_o(aOut2), .b_o(bOut2), .busy_o(busy2), .done_o(done2), .pass_o(pass2),
    .errCnt_o(errCnt2), .failMask_o(failMask2)
  );

  // Device model: ideal NOR, or gate 3 stuck low.
  always_comb begin
    yIn = ~(aOut | bOut);
    if (yMode == 2'd1) yIn[3] = 1'b0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic ab);
    start = st;
    abort = ab;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rstN  = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    yMode = 2'd0;
    runCycles(3);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_pass", 32'(pass), 32'd0);
    checkOutput("rst_err", 32'(errCnt), 32'd0);
    checkOutput("rst_mask", 32'(failMask), 32'd0);
    checkOutput("rst_ab", 32'({aOut, bOut}), 32'd0);
    rstN = 1'b1;
    runCycles(2);

    $display("[TB] case 1: ideal device");
    applyStimulus(1'b1, 1'b0);
    checkOutput("c1_busy", 32'(busy), 32'd1);
    runCycles(2);
    checkOutput("c1_step0_a", 32'(aOut), 32'h0);
    checkOutput("c1_step0_b", 32'(bOut), 32'h0);
    runCycles(24);
    checkOutput("c1_step4_a", 32'(aOut), 32'b0110);
    checkOutput("c1_step4_b", 32'(bOut), 32'b0101);
    checkOutput("c1_sat_step4_a", 32'(aOut2), 32'b0110);
    runCycles(6);
    checkOutput("c1_step5_a", 32'(aOut), 32'b0011);
    checkOutput("c1_step5_b", 32'(bOut), 32'b1010);
    runCycles(15);
    checkOutput("c1_done_c48", 32'(done), 32'd0);
    runCycles(1);
    checkOutput("c1_done_c49", 32'(done), 32'd1);
    checkOutput("c1_pass", 32'(pass), 32'd1);
    checkOutput("c1_err", 32'(errCnt), 32'd0);
    checkOutput("c1_mask", 32'(failMask), 32'b0000);
    checkOutput("c1_ab_idle", 32'({aOut, bOut}), 32'd0);
    runCycles(1);
    checkOutput("c1_done_c50", 32'(done), 32'd0);
    checkOutput("c1_busy_c50", 32'(busy), 32'd0);
    checkOutput("c1_pass_hold", 32'(pass), 32'd1);
    runCycles(2);

    $display("[TB] case 2/3: gate 3 stuck low, saturating instance all ones");
    yMode = 2'd1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("c2_pass_cleared", 32'(pass), 32'd0);
    runCycles(18);
    checkOutput("c3_err_after_step2", 32'(errCnt2), 32'd8);
    runCycles(30);
    checkOutput("c2_done", 32'(done), 32'd1);
    checkOutput("c2_err", 32'(errCnt), 32'd2);
    checkOutput("c2_mask", 32'(failMask), 32'b0100);
    checkOutput("c2_pass", 32'(pass), 32'd0);
    checkOutput("c3_done", 32'(done2), 32'd1);
    checkOutput("c3_err_sat", 32'(errCnt2), 32'd15);
    checkOutput("c3_mask", 32'(failMask2), 32'b1111);
    checkOutput("c3_pass", 32'(pass2), 32'd0);
    runCycles(3);

    $display("[TB] case 4: abort at cycle 10");
    applyStimulus(1'b1, 1'b0);
    runCycles(9);
    applyStimulus(1'b0, 1'b1);
    checkOutput("c4_busy", 32'(busy), 32'd0);
    checkOutput("c4_ab", 32'({aOut, bOut}), 32'd0);
    checkOutput("c4_pass", 32'(pass), 32'd0);
    checkOutput("c4_err_kept", 32'(errCnt), 32'd1);
    checkOutput("c4_mask_kept", 32'(failMask), 32'b0100);
    sawDone = 0;
    repeat (45) begin
      @(negedge clk);
      if (done) sawDone = 1;
    end
    checkOutput("c4_no_done", 32'(sawDone), 32'd0);

    $display("[TB] start and abort together in idle");
    applyStimulus(1'b1, 1'b1);
    checkOutput("sa_busy", 32'(busy), 32'd0);
    runCycles(1);
    checkOutput("sa_busy_later", 32'(busy), 32'd0);

    $display("[TB] case 5: reset mid-run");
    applyStimulus(1'b1, 1'b0);
    runCycles(19);
    checkOutput("c5_step3_a", 32'(aOut), 32'b1111);
    checkOutput("c5_err_before", 32'(errCnt), 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("c5_busy", 32'(busy), 32'd0);
    checkOutput("c5_ab", 32'({aOut, bOut}), 32'd0);
    checkOutput("c5_err", 32'(errCnt), 32'd0);
    checkOutput("c5_mask", 32'(failMask), 32'd0);
    checkOutput("c5_done", 32'(done), 32'd0);
    @(negedge clk);
    rstN  = 1'b1;
    yMode = 2'd0;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0);
    runCycles(47);
    checkOutput("c5_rerun_c48", 32'(done), 32'd0);
    runCycles(1);
    checkOutput("c5_rerun_done", 32'(done), 32'd1);
    checkOutput("c5_rerun_pass", 32'(pass), 32'd1);
    runCycles(3);

    $display("[TB] case 6: start re-pulsed during run");
    applyStimulus(1'b1, 1'b0);
    runCycles(4);
    applyStimulus(1'b1, 1'b0);
    runCycles(24);
    applyStimulus(1'b1, 1'b0);
    runCycles(17);
    checkOutput("c6_done_c48", 32'(done), 32'd0);
    runCycles(1);
    checkOutput("c6_done_c49", 32'(done), 32'd1);
    checkOutput("c6_pass", 32'(pass), 32'd1);
    checkOutput("c6_err", 32'(errCnt), 32'd0);
    checkOutput("c6_mask", 32'(failMask), 32'b0000);
    runCycles(2);
    checkOutput("c6_busy_end", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
